// File: rtl/twiddle_cmul_5.sv
// Complex twiddle multiply Y=X*W via four serial products on a shared multiplier_5; ~4*(2+max(mask,mult))+1 cycles.
// in_ready only in IDLE; a finished Y is held with out_valid until out_ready, and a product timeout sets sticky err.
module twiddle_cmul_5 #(
    parameter int SCALE_SHIFT = 0,
    parameter int RDY_MASK    = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  x_re,
    input  logic [8:0]  x_im,
    input  logic [8:0]  w_re,
    input  logic [8:0]  w_im,
    output logic [8:0]  mul_a,
    output logic [8:0]  mul_b,
    output logic        mul_rst_n,
    input  logic [16:0] mul_prdct,
    input  logic        mul_rdy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] y_re,
    output logic [17:0] y_im,
    output logic        err
);

    localparam int MCW = (RDY_MASK < 2) ? 1 : $clog2(RDY_MASK + 1);
    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [8:0]         xr_q, xr_d, xi_q, xi_d, wr_q, wr_d, wi_q, wi_d;
    logic [MCW-1:0]     mask_q, mask_d;
    logic [WCW-1:0]     wait_q, wait_d;
    logic [15:0]        prod_q, prod_d;
    logic signed [17:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [17:0] y_re_q, y_re_d, y_im_q, y_im_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [8:0]         mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic               mul_rst_n_q, mul_rst_n_d;
    logic               err_q, err_d;
    logic signed [17:0] p_ext;
    logic [17:0]        ops;

    // Bit 16 of the multiplier result carries no information for this stage.
    logic unused_prdct_msb;
    assign unused_prdct_msb = mul_prdct[16];

    function automatic logic [17:0] pick_ops(input logic [1:0] i, input logic [8:0] xr, input logic [8:0] xi,
                                             input logic [8:0] wr, input logic [8:0] wi);
        logic [17:0] r;
        case (i)
            2'd0:    r = {xr, wr};
            2'd1:    r = {xi, wi};
            2'd2:    r = {xr, wi};
            default: r = {xi, wr};
        endcase
        return r;
    endfunction

    // Signed product from the latched magnitude and the operand signs still held on mul_a/mul_b.
    always_comb begin
        p_ext = (mul_a_q[8] ^ mul_b_q[8]) ? -$signed({2'b00, prod_q}) : $signed({2'b00, prod_q});
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xr_d     = xr_q;
        xi_d     = xi_q;
        wr_d     = wr_q;
        wi_d     = wi_q;
        mask_d   = mask_q;
        wait_d   = wait_q;
        prod_d   = prod_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        y_re_d   = y_re_q;
        y_im_d   = y_im_q;
        err_d    = err_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        ops      = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    xr_d    = x_re;
                    xi_d    = x_im;
                    wr_d    = w_re;
                    wi_d    = w_im;
                    idx_d   = 2'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                mask_d  = MCW'(RDY_MASK);
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (mask_q != '0) begin
                    mask_d = mask_q - 1'b1;
                end
                if (mask_q == '0 && mul_rdy) begin
                    prod_d  = mul_prdct[15:0];
                    state_d = S_ACC;
                end else if (wait_q == WCW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (idx_q == 2'd1) begin
                    acc_re_d = acc_re_q - p_ext;
                end else if (idx_q == 2'd0) begin
                    acc_re_d = acc_re_q + p_ext;
                end else begin
                    acc_im_d = acc_im_q + p_ext;
                end
                if (idx_q == 2'd3) begin
                    y_re_d  = acc_re_d >>> SCALE_SHIFT;
                    y_im_d  = acc_im_d >>> SCALE_SHIFT;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_START;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    acc_re_d = '0;
                    acc_im_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_START) begin
            ops     = pick_ops(idx_d, xr_d, xi_d, wr_d, wi_d);
            mul_a_d = ops[17:9];
            mul_b_d = ops[8:0];
        end
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        mul_rst_n_d = (state_d != S_START);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            xr_q        <= '0;
            xi_q        <= '0;
            wr_q        <= '0;
            wi_q        <= '0;
            mask_q      <= '0;
            wait_q      <= '0;
            prod_q      <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            y_re_q      <= '0;
            y_im_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_rst_n_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            xr_q        <= xr_d;
            xi_q        <= xi_d;
            wr_q        <= wr_d;
            wi_q        <= wi_d;
            mask_q      <= mask_d;
            wait_q      <= wait_d;
            prod_q      <= prod_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            y_re_q      <= y_re_d;
            y_im_q      <= y_im_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_rst_n_q <= mul_rst_n_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_rst_n = mul_rst_n_q;
    assign err       = err_q;

endmodule

// File: tb/tb_twiddle_cmul_5.sv
// Directed bench for twiddle_cmul_5 with a behavioural multiplier_5 model (rdy 9 cycles after release).
// A second instance with SCALE_SHIFT=1 sees a multiplier whose rdy is stuck high.
module tb_twiddle_cmul_5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, mul_rst_n, mul_rdy, out_valid, out_ready, err;
    logic [8:0]  x_re, x_im, w_re, w_im, mul_a, mul_b;
    logic [16:0] mul_prdct;
    logic [17:0] y_re, y_im;
    logic [15:0] prod0;

    logic        in_valid1, in_ready1, mul_rst_n1, mul_rdy1, out_valid1, out_ready1, err1;
    logic [8:0]  mul_a1, mul_b1;
    logic [16:0] mul_prdct1;
    logic [17:0] y_re1, y_im1;
    logic [15:0] prod1;

    twiddle_cmul_5 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_re(x_re), .x_im(x_im), .w_re(w_re), .w_im(w_im),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rst_n(mul_rst_n), .mul_prdct(mul_prdct), .mul_rdy(mul_rdy),
        .out_valid(out_valid), .out_ready(out_ready), .y_re(y_re), .y_im(y_im), .err(err)
    );

    twiddle_cmul_5 #(.SCALE_SHIFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .x_re(x_re), .x_im(x_im), .w_re(w_re), .w_im(w_im),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_rst_n(mul_rst_n1), .mul_prdct(mul_prdct1), .mul_rdy(mul_rdy1),
        .out_valid(out_valid1), .out_ready(out_ready1), .y_re(y_re1), .y_im(y_im1), .err(err1)
    );

    // Multiplier model; bit 16 is driven high to show it is ignored.
    int mcnt = 0;
    int pulse_cnt = 0;
    int pulse_base = 0;
    bit drop_idx1 = 1'b0;

    always @(posedge clk) begin
        if (!mul_rst_n) mcnt <= 0;
        else if (mcnt < 1000) mcnt <= mcnt + 1;
        if (!mul_rst_n && rst_n) pulse_cnt <= pulse_cnt + 1;
    end

    assign prod0      = mul_a[7:0] * mul_b[7:0];
    assign mul_prdct  = {1'b1, prod0};
    assign mul_rdy    = mul_rst_n && (mcnt >= 9) && !(drop_idx1 && (pulse_cnt - pulse_base == 2));
    assign prod1      = mul_a1[7:0] * mul_b1[7:0];
    assign mul_prdct1 = {1'b1, prod1};
    assign mul_rdy1   = 1'b1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] sm(input int v);
        logic [7:0] m;
        m = (v < 0) ? 8'(-v) : 8'(v);
        return {(v < 0), m};
    endfunction

    task automatic send(input logic [8:0] xr, input logic [8:0] xi, input logic [8:0] wr, input logic [8:0] wi);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        x_re = xr; x_im = xi; w_re = wr; w_im = wi;
        pulse_base = pulse_cnt;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic get(output int yr, output int yi);
        wait_out();
        yr = int'($signed(y_re));
        yi = int'($signed(y_im));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [8:0] xr, xi, wr, wi;
        int         er, ei;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int yr, yi, n;
        bit hold_ok;

        vecs[0] = '{sm(3),    sm(4),    sm(2),   9'h101,   10,      5};
        vecs[1] = '{sm(-255), sm(255),  sm(255), sm(255),  -130050, 0};
        vecs[2] = '{9'h100,   9'h000,   sm(255), sm(-255), 0,       0};
        vecs[3] = '{sm(1),    sm(0),    sm(0),   sm(1),    0,       1};
        vecs[4] = '{sm(-5),   sm(7),    sm(-3),  sm(-2),   29,      -11};
        vecs[5] = '{sm(100),  sm(-200), sm(-7),  sm(9),    1100,    2300};
        vecs[6] = '{sm(255),  sm(-255), sm(255), sm(255),  130050,  0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        x_re = '0; x_im = '0; w_re = '0; w_im = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_re", y_re, 0);
        chk("rst_y_im", y_im, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_mul_rst_n", mul_rst_n, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].xr, vecs[i].xi, vecs[i].wr, vecs[i].wi);
            get(yr, yi);
            chk($sformatf("vec%0d_y_re", i), yr, vecs[i].er);
            chk($sformatf("vec%0d_y_im", i), yi, vecs[i].ei);
            chk($sformatf("vec%0d_mul_pulses", i), pulse_cnt - pulse_base, 4);
        end
        chk("table_err", err, 0);

        // Output backpressure: Y held, no new capture.
        send(vecs[0].xr, vecs[0].xi, vecs[0].wr, vecs[0].wi);
        wait_out();
        hold_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (!out_valid || $signed(y_re) != 10 || $signed(y_im) != 5 || in_ready) hold_ok = 1'b0;
            in_valid = (c == 5);
            x_re = sm(100); x_im = sm(-200); w_re = sm(-7); w_im = sm(9);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("hold_stable", int'(hold_ok), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        send(vecs[1].xr, vecs[1].xi, vecs[1].wr, vecs[1].wi);
        get(yr, yi);
        chk("after_hold_y_re", yr, -130050);
        chk("after_hold_y_im", yi, 0);

        // Reset while waiting on the third product.
        send(vecs[0].xr, vecs[0].xi, vecs[0].wr, vecs[0].wi);
        n = 0;
        while (pulse_cnt - pulse_base < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx2", pulse_cnt - pulse_base, 3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_mul_rst_n", mul_rst_n, 0);
        chk("midrst_mul_a", mul_a, 0);
        chk("midrst_mul_b", mul_b, 0);
        chk("midrst_y_re", y_re, 0);
        chk("midrst_y_im", y_im, 0);
        chk("midrst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send(vecs[0].xr, vecs[0].xi, vecs[0].wr, vecs[0].wi);
        get(yr, yi);
        chk("postrst_y_re", yr, 10);
        chk("postrst_y_im", yi, 5);

        // Second product never becomes ready.
        drop_idx1 = 1'b1;
        send(vecs[0].xr, vecs[0].xi, vecs[0].wr, vecs[0].wi);
        get(yr, yi);
        drop_idx1 = 1'b0;
        chk("timeout_y_re", yr, 6);
        chk("timeout_y_im", yi, 5);
        chk("timeout_err", err, 1);
        send(vecs[0].xr, vecs[0].xi, vecs[0].wr, vecs[0].wi);
        get(yr, yi);
        chk("clean_y_re", yr, 10);
        chk("clean_y_im", yi, 5);
        chk("err_sticky", err, 1);

        // Stuck-high rdy on the SCALE_SHIFT=1 instance.
        n = 0;
        while (!in_ready1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dut1_in_ready", in_ready1, 1);
        x_re = vecs[0].xr; x_im = vecs[0].xi; w_re = vecs[0].wr; w_im = vecs[0].wi;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        n = 1;
        while (!out_valid1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("dut1_out_valid", out_valid1, 1);
        chk("dut1_mask_latency", int'(n >= 17 && n <= 21), 1);
        chk("dut1_y_re", int'($signed(y_re1)), 5);
        chk("dut1_y_im", int'($signed(y_im1)), 2);
        chk("dut1_err", err1, 0);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("dut1_release", out_valid1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
